wb_bus_monitor: RTL and testbench

// Synthesizable, parametrised Wishbone classic-cycle protocol monitor. Taps a master/slave link

---
 rtl/wb_bus_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_wb_bus_monitor.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_monitor.sv
// Passive Wishbone classic-cycle monitor: handshake checks, sticky error flags, transfer stats.
// Latency: flags, counters and max wait update one cycle after the edge that caused them.
// Backpressure: none; the monitor only observes and never drives or stalls the bus.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_wb_adr/dat_m/dat_s/sel     tapped address, write data, read data (unchecked), byte selects
//   i_wb_cyc/stb/we/ack          tapped control/handshake
//   i_clr                        synchronous clear of flags, counters, max wait, error address
//   o_err[4:0]                   sticky {STB_NO_CYC, SPUR_ACK, CHANGE, DROP, TIMEOUT}
//   o_err_irq                    OR of o_err
//   o_err_adr                    bus address at first error since reset/clear
//   o_rd_cnt/o_wr_cnt            saturating completed read/write counts
//   o_max_wait                   largest request-to-ack wait seen
//   o_busy                       request outstanding (FSM not idle)
module wb_bus_monitor #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 16,
    localparam int WW     = $clog2(TIMEOUT + 1),
    localparam int SW     = DW / 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [AW-1:0]    i_wb_adr,
    input  logic [DW-1:0]    i_wb_dat_m,
    input  logic [DW-1:0]    i_wb_dat_s,
    input  logic [SW-1:0]    i_wb_sel,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic             i_wb_ack,
    input  logic             i_clr,
    output logic [4:0]       o_err,
    output logic             o_err_irq,
    output logic [AW-1:0]    o_err_adr,
    output logic [CNT_W-1:0] o_rd_cnt,
    output logic [CNT_W-1:0] o_wr_cnt,
    output logic [WW-1:0]    o_max_wait,
    output logic             o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_TOUT} state_t;

    localparam logic [WW-1:0] TO_V = WW'(TIMEOUT);

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [AW-1:0]     adr_q;
    logic              we_q;
    logic [SW-1:0]     sel_q;
    logic [DW-1:0]     dat_q;

    logic [4:0]        err_q, err_d;
    logic [AW-1:0]     err_adr_q, err_adr_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [WW-1:0]     max_wait_q, max_wait_d;

    logic              req;
    logic              mismatch;
    logic              capture;
    logic              complete;
    logic              cpl_we;
    logic [WW-1:0]     cpl_wait;
    logic [4:0]        ev;

    // Slave read data is not checked; reduced here only so the tap is consumed.
    logic unused_dat_s;
    assign unused_dat_s = ^i_wb_dat_s;

    assign req = i_wb_cyc & i_wb_stb;

    // Write data only matters when the captured transfer is a write.
    assign mismatch = (i_wb_adr != adr_q) | (i_wb_we != we_q) | (i_wb_sel != sel_q) |
                      (we_q & (i_wb_dat_m != dat_q));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req && !i_wb_ack) state_d = S_WAIT;
            S_WAIT: begin
                if (!req || i_wb_ack)  state_d = S_IDLE;
                else if (wait_q == TO_V) state_d = S_TOUT;
            end
            S_TOUT: if (i_wb_ack || !req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Per-cycle events derived from the current state and bus
    always_comb begin
        capture  = 1'b0;
        complete = 1'b0;
        cpl_we   = 1'b0;
        cpl_wait = '0;
        wait_d   = '0;
        ev       = '0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (i_wb_ack) begin
                        complete = 1'b1;
                        cpl_we   = i_wb_we;
                    end else begin
                        capture = 1'b1;
                        wait_d  = WW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (!req) begin
                    ev[1] = 1'b1;
                end else begin
                    ev[2] = mismatch;
                    if (i_wb_ack) begin
                        complete = 1'b1;
                        cpl_we   = we_q;
                        cpl_wait = wait_q;
                    end else if (wait_q == TO_V) begin
                        ev[0] = 1'b1;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
            end
            default: ;
        endcase
        ev[3] = i_wb_ack & ~req;
        ev[4] = i_wb_stb & ~i_wb_cyc;
    end

    // Statistics: i_clr zeroes the base value, so a same-cycle event still lands on top of it.
    always_comb begin
        logic [4:0]       err_base;
        logic [CNT_W-1:0] rd_base, wr_base;
        logic [WW-1:0]    max_base;
        err_base   = i_clr ? '0 : err_q;
        rd_base    = i_clr ? '0 : rd_cnt_q;
        wr_base    = i_clr ? '0 : wr_cnt_q;
        max_base   = i_clr ? '0 : max_wait_q;
        err_d      = err_base | ev;
        err_adr_d  = i_clr ? '0 : err_adr_q;
        rd_cnt_d   = rd_base;
        wr_cnt_d   = wr_base;
        max_wait_d = max_base;
        if (err_base == '0 && ev != '0) err_adr_d = i_wb_adr;
        if (complete) begin
            if (cpl_we) begin
                if (wr_base != '1) wr_cnt_d = wr_base + CNT_W'(1);
            end else begin
                if (rd_base != '1) rd_cnt_d = rd_base + CNT_W'(1);
            end
            if (cpl_wait > max_base) max_wait_d = cpl_wait;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_q     <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            err_q      <= '0;
            err_adr_q  <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            max_wait_q <= '0;
        end else begin
            wait_q     <= wait_d;
            err_q      <= err_d;
            err_adr_q  <= err_adr_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            max_wait_q <= max_wait_d;
            if (capture) begin
                adr_q <= i_wb_adr;
                we_q  <= i_wb_we;
                sel_q <= i_wb_sel;
                if (i_wb_we) dat_q <= i_wb_dat_m;
            end
        end
    end

    assign o_err      = err_q;
    assign o_err_irq  = |err_q;
    assign o_err_adr  = err_adr_q;
    assign o_rd_cnt   = rd_cnt_q;
    assign o_wr_cnt   = wr_cnt_q;
    assign o_max_wait = max_wait_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_wb_bus_monitor.sv
// Scoreboard bench for wb_bus_monitor with TIMEOUT=8.
// Stimulus pushes expected output snapshots; the monitor pops and compares on the falling edge.
// Inputs change 1 time unit after the rising edge.
module tb_wb_bus_monitor;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;
    localparam int CW = 16;
    localparam int WW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_m;
    logic [DW-1:0] dat_s;
    logic [3:0]    sel;
    logic          cyc, stb, we, ack, clr;

    logic [4:0]    o_err;
    logic          o_err_irq;
    logic [AW-1:0] o_err_adr;
    logic [CW-1:0] o_rd_cnt, o_wr_cnt;
    logic [WW-1:0] o_max_wait;
    logic          o_busy;

    always #5 clk = ~clk;

    wb_bus_monitor #(.DW(DW), .AW(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_adr   (adr),
        .i_wb_dat_m (dat_m),
        .i_wb_dat_s (dat_s),
        .i_wb_sel   (sel),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_ack   (ack),
        .i_clr      (clr),
        .o_err      (o_err),
        .o_err_irq  (o_err_irq),
        .o_err_adr  (o_err_adr),
        .o_rd_cnt   (o_rd_cnt),
        .o_wr_cnt   (o_wr_cnt),
        .o_max_wait (o_max_wait),
        .o_busy     (o_busy)
    );

    typedef struct {
        string         name;
        logic [4:0]    err;
        logic [AW-1:0] eadr;
        logic [CW-1:0] rd;
        logic [CW-1:0] wr;
        logic [WW-1:0] mx;
        logic          busy;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic cmp(input string nm, input string fld, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, req);
        end
    endtask

    task automatic exp_push(input string nm, input logic [4:0] er, input logic [AW-1:0] ea,
                            input logic [CW-1:0] r, input logic [CW-1:0] w,
                            input logic [WW-1:0] m, input logic b);
        exp_t e;
        e.name = nm; e.err = er; e.eadr = ea; e.rd = r; e.wr = w; e.mx = m; e.busy = b;
        q.push_back(e);
    endtask

    task automatic drv(input logic c, input logic s, input logic w, input logic k,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc = c; stb = s; we = w; ack = k; adr = a; dat_m = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every expectation pushed during a cycle is compared at that cycle's falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "err",      64'(o_err),      64'(e.err));
                cmp(e.name, "irq",      64'(o_err_irq),  64'(|e.err));
                cmp(e.name, "err_adr",  64'(o_err_adr),  64'(e.eadr));
                cmp(e.name, "rd_cnt",   64'(o_rd_cnt),   64'(e.rd));
                cmp(e.name, "wr_cnt",   64'(o_wr_cnt),   64'(e.wr));
                cmp(e.name, "max_wait", 64'(o_max_wait), 64'(e.mx));
                cmp(e.name, "busy",     64'(o_busy),     64'(e.busy));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : stim
        rst_n = 1'b1;
        clr   = 1'b0;
        sel   = 4'hF;
        dat_s = '0;
        drv(0, 0, 0, 0, '0, '0);
        #2 rst_n = 1'b0;
        step(); step();
        exp_push("reset", 5'b0, '0, 0, 0, 0, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Read, ack on the fourth cycle: wait 3
        drv(1, 1, 0, 0, 32'h100, '0);
        step();
        exp_push("rd_busy", 5'b0, '0, 0, 0, 0, 1'b1);
        step(); step();
        ack = 1'b1;
        step();
        drv(0, 0, 0, 0, '0, '0);
        exp_push("rd_done", 5'b0, '0, 1, 0, 3, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        exp_push("clr1", 5'b0, '0, 0, 0, 0, 1'b0);

        // Write acked same cycle, strobe held for two more acked cycles
        drv(1, 1, 1, 1, 32'h300, 32'hDEAD_BEEF);
        step();
        exp_push("wr_1", 5'b0, '0, 0, 1, 0, 1'b0);
        step(); step();
        drv(0, 0, 0, 0, '0, '0);
        exp_push("wr_3", 5'b0, '0, 0, 3, 0, 1'b0);

        // Timeout: no flag at wait 8, flag on the following edge
        drv(1, 1, 0, 0, 32'h400, '0);
        step();
        for (int i = 0; i < 7; i++) step();
        exp_push("to_pre", 5'b0, '0, 0, 3, 0, 1'b1);
        step();
        exp_push("to_fire", 5'b00001, 32'h400, 0, 3, 0, 1'b1);
        step();
        exp_push("to_hold", 5'b00001, 32'h400, 0, 3, 0, 1'b1);
        ack = 1'b1;
        step();
        drv(0, 0, 0, 0, '0, '0);
        exp_push("to_exit", 5'b00001, 32'h400, 0, 3, 0, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        exp_push("clr2", 5'b0, '0, 0, 0, 0, 1'b0);

        // Address change mid-wait, then strobe drop
        drv(1, 1, 0, 0, 32'h200, '0);
        step();
        adr = 32'h204;
        step();
        exp_push("chg", 5'b00100, 32'h204, 0, 0, 0, 1'b1);
        stb = 1'b0;
        step();
        cyc = 1'b0;
        exp_push("drop", 5'b00110, 32'h204, 0, 0, 0, 1'b0);

        clr = 1'b1; step(); clr = 1'b0;
        exp_push("clr3", 5'b0, '0, 0, 0, 0, 1'b0);

        // Spurious ack and strobe without cycle in the same cycle
        drv(0, 1, 0, 1, 32'h500, '0);
        step();
        drv(0, 0, 0, 0, '0, '0);
        exp_push("spur_nocyc", 5'b11000, 32'h500, 0, 0, 0, 1'b0);

        // Read with wait 2; existing errors stay
        drv(1, 1, 0, 0, 32'h700, '0);
        step(); step();
        ack = 1'b1;
        step();
        drv(0, 0, 0, 0, '0, '0);
        exp_push("rd2", 5'b11000, 32'h500, 1, 0, 2, 1'b0);

        // Clear concurrent with a zero-wait read completion
        clr = 1'b1;
        drv(1, 1, 0, 1, 32'h710, '0);
        step();
        clr = 1'b0;
        drv(0, 0, 0, 0, '0, '0);
        exp_push("clr_cpl", 5'b0, '0, 1, 0, 0, 1'b0);

        // Clear concurrent with a spurious ack
        clr = 1'b1;
        drv(0, 0, 0, 1, 32'h600, '0);
        step();
        clr = 1'b0;
        drv(0, 0, 0, 0, '0, '0);
        exp_push("clr_e3", 5'b01000, 32'h600, 0, 0, 0, 1'b0);

        // Reset asserted between edges while waiting
        drv(1, 1, 0, 0, 32'h800, '0);
        step();
        exp_push("pre_rst", 5'b01000, 32'h600, 0, 0, 0, 1'b1);
        step();
        #1 rst_n = 1'b0;
        exp_push("async_rst", 5'b0, '0, 0, 0, 0, 1'b0);
        drv(0, 0, 0, 0, '0, '0);
        step(); step();
        rst_n = 1'b1;
        step();
        exp_push("post_rst", 5'b0, '0, 0, 0, 0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
